sd_dat_tx: RTL and testbench

SD_DAT_TX -- requirements
Module: sd_dat_tx

---
 rtl/sd_dat_tx.sv | 128 ++++++++++++
 tb/tb_sd_dat_tx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sd_dat_tx.sv
// sd_dat_tx: serial SD DAT-line block transmitter.
// Frame is start bit, BLOCK_LEN bytes MSB first, CRC16 (x^16+x^12+x^5+1), end bit.
module sd_dat_tx #(
   parameter int BLOCK_LEN = 512
) (
   input  logic       clk,
   input  logic       en,
   input  logic       start,
   input  logic [7:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   output logic       dat_out,
   output logic       dat_oe,
   output logic       busy,
   output logic       done,
   output logic       underrun
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] DATA  = 3'd2;
   localparam logic [2:0] CRC   = 3'd3;
   localparam logic [2:0] END   = 3'd4;

   localparam logic [14:0] LAST_BIT = 15'(8 * BLOCK_LEN - 1);
   localparam logic [12:0] N_BYTES  = 13'(BLOCK_LEN);

   logic [2:0]  state;
   logic [7:0]  hold_byte;
   logic        hold_full;
   logic [7:0]  shifter;
   logic [14:0] bit_cnt;
   logic [12:0] fetched;
   logic [15:0] crc;

   logic        load_req;
   logic        xfer;
   logic        crc_dx;
   logic [15:0] crc_next;

   always_comb begin
      load_req = (state == START) ||
                 ((state == DATA) && (bit_cnt[2:0] == 3'd7) && (bit_cnt != LAST_BIT));
      underrun = load_req && !hold_full;
      // en gates din_ready directly so it is low for the whole reset, not just after an edge
      din_ready = en && !hold_full && (fetched != N_BYTES) &&
                  ((state == IDLE) || (state == START) || (state == DATA));
      xfer     = din_valid && din_ready;
      crc_dx   = shifter[7] ^ crc[15];
      crc_next = {crc[14:12], crc[11] ^ crc_dx, crc[10:5], crc[4] ^ crc_dx, crc[3:0], crc_dx};
      dat_oe   = (state != IDLE);
      busy     = (state != IDLE);
      done     = (state == END);
      case (state)
         START:   dat_out = 1'b0;
         DATA:    dat_out = shifter[7];
         CRC:     dat_out = crc[4'd15 - bit_cnt[3:0]];
         default: dat_out = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge en) begin
      if (!en) begin
         state     <= IDLE;
         hold_byte <= '0;
         hold_full <= 1'b0;
         shifter   <= '0;
         bit_cnt   <= '0;
         fetched   <= '0;
         crc       <= '0;
      end else begin
         if (xfer) begin
            hold_byte <= din;
            hold_full <= 1'b1;
            fetched   <= fetched + 13'd1;
         end
         case (state)
            IDLE: begin
               crc     <= '0;
               bit_cnt <= '0;
               if (start) state <= START;
            end
            START: begin
               bit_cnt <= '0;
               if (!hold_full) begin
                  state     <= IDLE;
                  hold_full <= 1'b0;
                  fetched   <= '0;
               end else begin
                  shifter   <= hold_byte;
                  hold_full <= 1'b0;
                  state     <= DATA;
               end
            end
            DATA: begin
               crc     <= crc_next;
               bit_cnt <= bit_cnt + 15'd1;
               if (bit_cnt == LAST_BIT) begin
                  bit_cnt <= '0;
                  state   <= CRC;
               end else if (load_req) begin
                  // an underrun discards anything accepted on the aborting edge
                  if (!hold_full) begin
                     state     <= IDLE;
                     hold_full <= 1'b0;
                     fetched   <= '0;
                  end else begin
                     shifter   <= hold_byte;
                     hold_full <= 1'b0;
                  end
               end else begin
                  shifter <= {shifter[6:0], 1'b0};
               end
            end
            CRC: begin
               bit_cnt <= bit_cnt + 15'd1;
               if (bit_cnt[3:0] == 4'd15) state <= END;
            end
            END: begin
               fetched <= '0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_dat_tx.sv
// Directed bench for sd_dat_tx: three instances (BLOCK_LEN 9, 512, 4) sharing clock and en.
module tb_sd_dat_tx;

   logic       clk = 1'b0;
   logic       en;
   logic [2:0] start_v;
   logic [7:0] din_v [3];
   logic [2:0] din_valid_v;
   logic [2:0] din_ready_v;
   logic [2:0] dat_out_v;
   logic [2:0] dat_oe_v;
   logic [2:0] busy_v;
   logic [2:0] done_v;
   logic [2:0] underrun_v;

   int n_checks = 0;
   int n_fail   = 0;

   logic bits [$];
   int   r_first_oe, r_done_cnt, r_done_pos, r_und_cnt, r_und_pos, r_busy_err;
   bit   r_timeout;

   always #5 clk = ~clk;

   sd_dat_tx #(.BLOCK_LEN(9)) u_blk9 (
      .clk(clk), .en(en), .start(start_v[0]), .din(din_v[0]), .din_valid(din_valid_v[0]),
      .din_ready(din_ready_v[0]), .dat_out(dat_out_v[0]), .dat_oe(dat_oe_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .underrun(underrun_v[0]));

   sd_dat_tx #(.BLOCK_LEN(512)) u_blk512 (
      .clk(clk), .en(en), .start(start_v[1]), .din(din_v[1]), .din_valid(din_valid_v[1]),
      .din_ready(din_ready_v[1]), .dat_out(dat_out_v[1]), .dat_oe(dat_oe_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .underrun(underrun_v[1]));

   sd_dat_tx #(.BLOCK_LEN(4)) u_blk4 (
      .clk(clk), .en(en), .start(start_v[2]), .din(din_v[2]), .din_valid(din_valid_v[2]),
      .din_ready(din_ready_v[2]), .dat_out(dat_out_v[2]), .dat_oe(dat_oe_v[2]),
      .busy(busy_v[2]), .done(done_v[2]), .underrun(underrun_v[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] byte_of(input int kind, input int i);
      case (kind)
         0:       return 8'h31 + 8'(i);
         1:       return 8'hFF;
         default: return 8'h00;
      endcase
   endfunction

   // Drives one block on instance u and records every dat_oe=1 cycle into bits.
   // stall_at: byte index whose din_valid is withheld; rst_at: bits count at which en drops.
   task automatic tx(input int u, input int nbytes, input int kind, input int stall_at,
                     input bit hold_start, input bit extra_start, input int rst_at);
      int idx;
      int cyc;
      bit pend;
      bit seen_oe;
      bit fin;
      bits.delete();
      r_first_oe = -1; r_done_cnt = 0; r_done_pos = -1;
      r_und_cnt = 0; r_und_pos = -1; r_busy_err = 0;
      seen_oe = 1'b0; fin = 1'b0; cyc = 0; idx = 0;
      @(negedge clk);
      start_v[u]     = 1'b1;
      din_v[u]       = byte_of(kind, 0);
      din_valid_v[u] = (stall_at != 0);
      pend = din_valid_v[u] && din_ready_v[u];
      while (!fin && cyc < 8 * nbytes + 64) begin
         @(negedge clk);
         cyc++;
         start_v[u] = hold_start && !(extra_start && bits.size() == 8 * nbytes + 4);
         if (pend) begin
            idx++;
            din_v[u]       = byte_of(kind, idx);
            din_valid_v[u] = (idx < nbytes) && (idx != stall_at);
         end
         if (busy_v[u] !== dat_oe_v[u]) r_busy_err++;
         if (dat_oe_v[u]) begin
            if (!seen_oe) r_first_oe = cyc;
            seen_oe = 1'b1;
            bits.push_back(dat_out_v[u]);
         end else if (seen_oe) begin
            fin = 1'b1;
         end
         if (done_v[u]) begin r_done_cnt++; r_done_pos = bits.size(); end
         if (underrun_v[u]) begin r_und_cnt++; r_und_pos = bits.size(); end
         if (rst_at >= 0 && bits.size() == rst_at && !fin) begin
            #2 en = 1'b0;
            #1;
            check("async rst dat_oe", 32'(dat_oe_v[u]), 0);
            check("async rst busy", 32'(busy_v[u]), 0);
            check("async rst dat_out", 32'(dat_out_v[u]), 1);
            check("async rst din_ready", 32'(din_ready_v[u]), 0);
            fin = 1'b1;
         end
         pend = din_valid_v[u] && din_ready_v[u];
      end
      r_timeout      = !fin;
      din_valid_v[u] = 1'b0;
      if (!hold_start) start_v[u] = 1'b0;
   endtask

   task automatic check_block(input string tag, input int nbytes, input int kind,
                              input logic [15:0] exp_crc);
      logic [15:0] crcf;
      logic [7:0]  b;
      int          derr;
      check({tag, " timeout"}, 32'(r_timeout), 0);
      check({tag, " oe cycles"}, bits.size(), 8 * nbytes + 18);
      check({tag, " start latency"}, r_first_oe, 1);
      if (bits.size() == 8 * nbytes + 18) begin
         check({tag, " start bit"}, 32'(bits[0]), 0);
         derr = 0;
         for (int i = 0; i < nbytes; i++) begin
            b = byte_of(kind, i);
            for (int j = 0; j < 8; j++)
               if (bits[1 + 8 * i + j] !== b[7 - j]) derr++;
         end
         check({tag, " data bit errors"}, derr, 0);
         for (int k = 0; k < 16; k++) crcf[15 - k] = bits[1 + 8 * nbytes + k];
         check({tag, " crc field"}, 32'(crcf), 32'(exp_crc));
         check({tag, " end bit"}, 32'(bits[bits.size() - 1]), 1);
      end
      check({tag, " done count"}, r_done_cnt, 1);
      check({tag, " done in end cycle"}, r_done_pos, 8 * nbytes + 18);
      check({tag, " underrun count"}, r_und_cnt, 0);
      check({tag, " busy tracks oe"}, r_busy_err, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      en = 1'b0;
      start_v = '0;
      din_valid_v = '0;
      for (int i = 0; i < 3; i++) din_v[i] = 8'h00;
      #3;
      check("reset dat_oe", 32'(dat_oe_v), 0);
      check("reset dat_out", 32'(dat_out_v), 32'h7);
      check("reset din_ready", 32'(din_ready_v), 0);
      check("reset busy", 32'(busy_v), 0);
      check("reset done/underrun", 32'({done_v, underrun_v}), 0);
      #19 en = 1'b1;

      tx(0, 9, 0, -1, 1'b0, 1'b0, -1);
      check_block("ascii9", 9, 0, 16'h31C3);

      tx(1, 512, 1, -1, 1'b0, 1'b0, -1);
      check_block("ff512", 512, 1, 16'h7FA1);

      tx(2, 4, 2, 2, 1'b0, 1'b0, -1);
      check("under timeout", 32'(r_timeout), 0);
      check("under oe cycles", bits.size(), 17);
      check("under count", r_und_cnt, 1);
      check("under in last oe cycle", r_und_pos, 17);
      check("under no done", r_done_cnt, 0);
      tx(2, 4, 2, -1, 1'b0, 1'b0, -1);
      check_block("zero4", 4, 2, 16'h0000);

      tx(0, 9, 0, -1, 1'b0, 1'b0, 12);
      @(posedge clk);
      #1;
      check("rst held dat_oe", 32'(dat_oe_v[0]), 0);
      #1 en = 1'b1;
      tx(0, 9, 0, -1, 1'b0, 1'b0, -1);
      check_block("after reset", 9, 0, 16'h31C3);

      tx(0, 9, 0, -1, 1'b1, 1'b1, -1);
      check_block("held start", 9, 0, 16'h31C3);
      @(negedge clk);
      check("restart dat_oe", 32'(dat_oe_v[0]), 1);
      check("restart start bit", 32'(dat_out_v[0]), 0);
      check("restart empty underrun", 32'(underrun_v[0]), 1);
      start_v[0] = 1'b0;
      @(negedge clk);
      check("restart abort dat_oe", 32'(dat_oe_v[0]), 0);
      check("restart abort busy", 32'(busy_v[0]), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
